// File: rtl/grid_position_tracker_if.sv
// Direction/position bundle between the direction controller,
// the grid_position_tracker and the display/collision logic.
interface grid_position_tracker_if #(
    parameter int XW = 4,
    parameter int YW = 4
);
    logic [3:0]    dir;
    logic          pause;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          step;
    logic          wrapped;
    logic          hit_wall;

    modport master (
        output dir, pause,
        input  x, y, step, wrapped, hit_wall
    );

    modport slave (
        input  dir, pause,
        output x, y, step, wrapped, hit_wall
    );
endinterface

// File: rtl/grid_position_tracker.sv
// Turns a 4-bit direction word into an (x, y) grid position that
// advances once every TICK_DIV clocks, with wrap or halt at the edges.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave modport
//          dir[0] x enable, dir[1] x up, dir[2] y enable, dir[3] y up
//          pause    freezes prescaler and movement
//          x, y     current position (registered)
//          step     one-cycle pulse when a move event lands
//          wrapped  one-cycle pulse with step when an axis wrapped
//          hit_wall sticky, WRAP=0 only, set on a blocked move
module grid_position_tracker #(
    parameter int COLS     = 16,
    parameter int ROWS     = 12,
    parameter int TICK_DIV = 4,
    parameter int X_INIT   = 0,
    parameter int Y_INIT   = 0,
    parameter int WRAP     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    grid_position_tracker_if.slave bus
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int TW = $clog2(TICK_DIV) + 1;

    localparam logic [XW-1:0] X_MAX  = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(ROWS - 1);
    localparam logic [XW-1:0] X_RST  = XW'(X_INIT);
    localparam logic [YW-1:0] Y_RST  = YW'(Y_INIT);
    localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

    typedef enum logic {RUN, HALT} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d, x_mv;
    logic [YW-1:0] y_q, y_d, y_mv;
    logic [TW-1:0] tick_q, tick_d;
    logic          step_q, step_d;
    logic          wrap_q, wrap_d;
    logic          hit_q, hit_d;

    logic          x_en, x_up, x_edge, x_wrap;
    logic          y_en, y_up, y_edge, y_wrap;
    logic          ev;

    assign ev = (state_q == RUN) && !bus.pause && (tick_q == T_LAST);

    // Candidate next position per axis; the edge test is done on
    // the current value so no out-of-range value ever exists.
    always_comb begin
        x_en   = bus.dir[0];
        x_up   = bus.dir[1];
        y_en   = bus.dir[2];
        y_up   = bus.dir[3];
        x_edge = x_up ? (x_q == X_MAX) : (x_q == '0);
        y_edge = y_up ? (y_q == Y_MAX) : (y_q == '0);
        x_wrap = x_en && x_edge;
        y_wrap = y_en && y_edge;
        x_mv   = x_q;
        y_mv   = y_q;
        if (x_en) begin
            if (x_edge)
                x_mv = x_up ? '0 : X_MAX;
            else
                x_mv = x_up ? x_q + 1'b1 : x_q - 1'b1;
        end
        if (y_en) begin
            if (y_edge)
                y_mv = y_up ? '0 : Y_MAX;
            else
                y_mv = y_up ? y_q + 1'b1 : y_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        tick_d  = tick_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        hit_d   = hit_q;
        unique case (state_q)
            RUN: begin
                if (!bus.pause)
                    tick_d = (tick_q == T_LAST) ? '0 : tick_q + 1'b1;
                if (ev) begin
                    step_d = 1'b1;
                    // With WRAP=0 an edge crossing on either axis
                    // blocks the whole move, not just that axis.
                    if (WRAP == 0 && (x_wrap || y_wrap)) begin
                        hit_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        x_d    = x_mv;
                        y_d    = y_mv;
                        wrap_d = (WRAP != 0) && (x_wrap || y_wrap);
                    end
                end
            end
            HALT: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            x_q     <= X_RST;
            y_q     <= Y_RST;
            tick_q  <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tick_q  <= tick_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            hit_q   <= hit_d;
        end
    end

    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.step     = step_q;
    assign bus.wrapped  = wrap_q;
    assign bus.hit_wall = hit_q;
endmodule

// File: doc/grid_position_tracker.md
# grid_position_tracker

Converts the 4-bit direction word produced by the direction controller into an (x, y) grid position that advances at a programmable step rate. It sits directly downstream of the direction controller and feeds the display/collision logic. It contains a step-rate prescaler, column and row up/down counters, and a two-state run/halt FSM for the edge-of-grid policy.

## Interface
Parameters:
- COLS, default 16: number of grid columns; x ranges 0..COLS-1. Must be 2 or more.
- ROWS, default 12: number of grid rows; y ranges 0..ROWS-1. Must be 2 or more.
- TICK_DIV, default 4: clocks per movement step. Must be 1 or more.
- X_INIT, default 0: x value loaded on reset.
- Y_INIT, default 0: y value loaded on reset.
- WRAP, default 1: edge policy. 1 = wrap around; 0 = halt at the edge.
- XW = $clog2(COLS), YW = $clog2(ROWS), TW = $clog2(TICK_DIV)+1: derived widths, local only.

Ports:
- clk  in  1: single clock; all logic is on the rising edge.
- rst  in  1: reset, asynchronous, active-high.
- dir  in  4: direction word.
  - bit0: x count enable.
  - bit1: x direction (1 = increment, 0 = decrement).
  - bit2: y count enable.
  - bit3: y direction (1 = increment, 0 = decrement).
- pause  in  1: freezes the prescaler and movement while high.
- x  out  XW: current column.
- y  out  YW: current row.
- step  out  1: one-cycle pulse, high in the cycle the new x/y first appears.
- wrapped  out  1: one-cycle pulse, coincident with step, when any axis wrapped.
- hit_wall  out  1: sticky flag, WRAP=0 only; set on an attempted move past an edge.

## Operation
- Reset values: x=X_INIT, y=Y_INIT, step=0, wrapped=0, hit_wall=0, tick_cnt=0, state=RUN.
- Prescaler:
  - tick_cnt counts 0..TICK_DIV-1 while pause=0 and state=RUN, then returns to 0.
  - A move event occurs on the edge where tick_cnt==TICK_DIV-1 and pause=0.
  - With pause=1, tick_cnt holds its value. No event occurs.
  - With TICK_DIV=1, an event occurs every unpaused cycle.
- Move event:
  - dir is sampled on the event edge only; changes between events are ignored.
  - Each axis is updated independently. An axis with enable=0 holds, whatever its direction bit says.
  - Both axes enabled means a diagonal move, both updated on the same edge.
  - step is asserted for every event, including events where dir=0 or no axis moved.
- WRAP=1:
  - x increments from COLS-1 to 0, and decrements from 0 to COLS-1. y behaves the same way against ROWS.
  - wrapped=1 when either axis wrapped on that event.
  - hit_wall stays 0.
- WRAP=0, FSM states RUN and HALT:
  - RUN: on an event, if any enabled axis would leave its range, both axes hold (no partial move). step=1 is still pulsed, hit_wall is set to 1, and the state goes to HALT. Otherwise the move completes normally.
  - HALT: x, y and tick_cnt frozen; step and wrapped stay 0; hit_wall stays 1. Only rst leaves HALT.
- Arithmetic:
  - Compare against the limits before updating. No modulo operators.
  - x/y never take values outside their range, including when COLS or ROWS is not a power of 2.
- rst asserted mid-operation, including in HALT or with pause=1: all state returns to reset values immediately (asynchronous), and any pending event is discarded.

## Timing
- Latency:
  - After rst deasserts with pause=0, the first step occurs on the TICK_DIV-th rising edge.
  - x, y, step and wrapped all update on the same edge, all registered, with no combinational path from inputs to outputs.
- Event spacing: exactly TICK_DIV clocks between step pulses while unpaused. Paused cycles extend the spacing one-for-one.
- pause rising on an event edge suppresses that event. pause falling resumes counting from the held tick_cnt.
- hit_wall rises on the same edge as the blocked event's step pulse.

## Test plan
- COLS=4, ROWS=3, TICK_DIV=2, X_INIT=0, Y_INIT=0, WRAP=1; reset, then dir=4'b0011 for 4 events -> x sequence 1,2,3,0, with wrapped=1 only on the 3->0 event; y stays 0; step pulses every 2 clocks.
- Same config; dir=4'b0001 (x decrement) from x=0 -> x=3, wrapped=1. Then dir=4'b1100 (y increment) ×3 -> y sequence 1,2,0.
- Same config, dir=4'b1111 -> x and y both increment on each event (0,0)->(1,1)->(2,2)->(3,0), with wrapped=1 on the third event. Then dir=4'b0010 (enables off) -> position holds and step still pulses.
- WRAP=0, X_INIT=3, dir=4'b0011 -> first event: step=1, x stays 3, hit_wall=1. After that, no further step pulses for 10 events' worth of clocks, and x/y are unchanged with dir changed to 4'b0001.
- TICK_DIV=4; pause=1 held for 5 clocks starting when tick_cnt=2 -> the next step arrives exactly 5 clocks later than nominal, and position changes by one step only.
- Assert rst asynchronously between clock edges while in HALT and while mid-prescale -> outputs return to (X_INIT, Y_INIT), step=0, hit_wall=0 before the next edge, and the first step comes TICK_DIV edges after release.
